// File: rtl/btisa_fetch_unit_pkg.sv
// Shared types for the BTISA fetch stage: trit/instruction encodings,
// fetch FSM states and the trit legality helpers.
package btisa_fetch_unit_pkg;

  // Two-bit trit encoding; 2'b11 is the only illegal code.
  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;

  typedef trit_t [8:0] instr_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  function automatic logic trit_is_legal(trit_t t);
    return (t == T_NEG_ONE) || (t == T_ZERO) || (t == T_POS_ONE);
  endfunction

  // True when any trit of the word carries an illegal encoding.
  function automatic logic instr_has_fault(instr_t ins);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!trit_is_legal(ins[i])) f = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/btisa_fetch_unit_if.sv
// Instruction-memory request/response and fetch-to-decode handshake bundle.
// master = fetch unit, slave = memory + decoder side.
interface btisa_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  import btisa_fetch_unit_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  instr_t            imem_rsp_data;

  logic              if_valid;
  logic              if_ready;
  instr_t            if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_instr, if_pc, if_fault,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_instr, if_pc, if_fault,
    output if_ready
  );

endinterface

// File: rtl/btisa_fetch_unit_fifo.sv
// Small in-order buffer of {pc, instruction} entries with synchronous flush.
// The head reads as all-zero while the buffer is empty so downstream sees
// clean idle values.
module btisa_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 26
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [W-1:0]                 head_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers and occupancy; flush discards everything,
  // including a push arriving in the same cycle.
  always_comb begin
    push_ok = push_i && !flush_i;
    pop_ok  = pop_i && (cnt_q != '0);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = ptr_inc(wr_q);
      if (pop_ok)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/btisa_fetch_unit.sv
// BTISA instruction fetch stage: issues word addresses to instruction memory
// under a credit limit, tags in-order responses with their PC, buffers them,
// and hands them to decode. Redirect and HALT flush the buffer and mark all
// in-flight responses for discard.
module btisa_fetch_unit
  import btisa_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  btisa_fetch_unit_if.master bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INS_W = $bits(instr_t);
  localparam int ENT_W = ADDR_W + INS_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d, drop_q, drop_d;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [ENT_W-1:0]  head;
  logic [CNT_W:0]    credit_used;
  logic              req_valid, req_fire, rsp_ok, push, pop, flush;

  // Issue, response accounting and FSM next-state. A pop in the current
  // cycle frees a buffer slot, so it is credited back before the limit test;
  // this keeps back-to-back fetch at one per cycle with single-cycle memory.
  always_comb begin
    pop         = (fifo_cnt != '0) && bus.if_ready;
    credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt} - {{CNT_W{1'b0}}, pop};
    req_valid   = !rst && (state_q == S_RUN) && !redirect_valid && !halt &&
                  (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    req_fire    = req_valid && bus.imem_req_ready;
    rsp_ok      = bus.imem_rsp_valid && (outst_q != '0);
    flush       = redirect_valid || halt;
    push        = rsp_ok && (drop_q == '0) && !flush;
    outst_d     = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);

    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;

    if (flush) begin
      // Everything still in flight belongs to the squashed path.
      drop_d = outst_d;
    end else if (rsp_ok && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    if (redirect_valid) begin
      state_d  = S_RUN;
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
    end else begin
      if (halt)     state_d  = S_HALT;
      if (req_fire) pc_d     = pc_q + ADDR_W'(1);
      if (push)     rsp_pc_d = rsp_pc_q + ADDR_W'(1);
    end
  end

  // FSM, PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  btisa_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({rsp_pc_q, bus.imem_rsp_data}),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (fifo_cnt),
    .head_o      (head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = (fifo_cnt != '0);
  assign bus.if_pc          = head[ENT_W-1 -: ADDR_W];
  assign bus.if_instr       = head[INS_W-1:0];
  assign bus.if_fault       = instr_has_fault(head[INS_W-1:0]);
  assign halted             = (state_q == S_HALT);

  // A response with nothing outstanding means the memory broke ordering.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && (outst_q == '0)));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, outst_q} + {1'b0, fifo_cnt}) <= (CNT_W+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_btisa_fetch_unit.sv
// Bench for btisa_fetch_unit: in-order latency memory model, decoder
// driver, and a stream scoreboard that expects consecutive PCs from the last
// reset/redirect target with data taken from the memory image.
module tb_btisa_fetch_unit;
  import btisa_fetch_unit_pkg::*;

  localparam int         AW     = 8;
  localparam logic [7:0] RST_PC = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halt;
  logic       halted;

  btisa_fetch_unit_if #(.ADDR_W(AW)) bus ();

  btisa_fetch_unit #(
    .ADDR_W     (AW),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  instr_t mem [256];
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_fault(instr_t x);
    for (int i = 0; i < 9; i++)
      if (!(x[i] inside {T_NEG_ONE, T_ZERO, T_POS_ONE})) return 1'b1;
    return 1'b0;
  endfunction

  function automatic instr_t rand_legal();
    instr_t x;
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 2))
        0:       x[i] = T_NEG_ONE;
        1:       x[i] = T_ZERO;
        default: x[i] = T_POS_ONE;
      endcase
    end
    return x;
  endfunction

  // ---------------- memory + decoder-ready model ----------------
  typedef struct { logic [7:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;
  bit    rand_lat = 0, rand_rdy = 0, rand_ifr = 0;
  int    fires = 0;

  // Record accepted requests (inputs are stable between negedge and posedge).
  initial begin
    forever begin
      @(negedge clk);
      if (rst) mq.delete();
      else if (bus.imem_req_valid && bus.imem_req_ready) begin
        int l;
        l = rand_lat ? int'($urandom_range(1, 3)) : lat;
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + l});
        fires++;
      end
    end
  end

  // Drive responses in order once their latency has elapsed.
  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.imem_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rand_ifr) bus.if_ready = ($urandom_range(0, 3) != 0);
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem[mq[0].addr];
        void'(mq.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  // ---------------- stream scoreboard ----------------
  logic [7:0] exp_pc = RST_PC;
  bit         halted_m = 0;
  int         pops = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc   = RST_PC;
        halted_m = 0;
      end else begin
        check("halted", halted, halted_m);
        if (halted_m) check("req_while_halted", bus.imem_req_valid, 1'b0);
        if (bus.if_valid && bus.if_ready) begin
          check("pop_while_halted", halted_m, 1'b0);
          check("if_pc", bus.if_pc, exp_pc);
          check("if_instr", bus.if_instr, mem[exp_pc]);
          check("if_fault", bus.if_fault, ref_fault(mem[exp_pc]));
          exp_pc++;
          pops++;
        end else if (!bus.if_valid) begin
          check("fault_idle", bus.if_fault, 1'b0);
        end
        if (redirect_valid) begin
          exp_pc   = redirect_pc;
          halted_m = 0;
        end else if (halt) begin
          halted_m = 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic next_pop(input string nm, output logic [7:0] pc,
                          output instr_t ins, output logic flt);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.if_valid && bus.if_ready) && n < 60);
    check({nm, "_arrives"}, bus.if_valid && bus.if_ready, 1'b1);
    pc  = bus.if_pc;
    ins = bus.if_instr;
    flt = bus.if_fault;
  endtask

  task automatic pulse_redirect(input logic [7:0] a);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = a;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic pulse_halt();
    @(posedge clk); #1;
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
  endtask

  typedef struct { instr_t instr; logic fault; } vec_t;
  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pc;
    instr_t     ins;
    logic       flt;
    int         n, f0, p0;

    tbl[0] = '{instr: 18'h00000, fault: 1'b0};
    tbl[1] = '{instr: 18'h15555, fault: 1'b0};
    tbl[2] = '{instr: 18'h2AAAA, fault: 1'b0};
    tbl[3] = '{instr: 18'h00003, fault: 1'b1};
    tbl[4] = '{instr: 18'h30000, fault: 1'b1};
    tbl[5] = '{instr: 18'h3FFFF, fault: 1'b1};

    for (int a = 0; a < 256; a++) mem[a] = rand_legal();
    mem[5][3] = 2'b11;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    bus.if_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_if_instr", bus.if_instr, 18'h0);
    check("rst_if_pc", bus.if_pc, 8'h00);
    check("rst_if_fault", bus.if_fault, 1'b0);
    check("rst_halted", halted, 1'b0);

    // 1. latency and throughput, wrapping from 255
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("lat_not_yet", bus.if_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    check("lat_first_valid", bus.if_valid, 1'b1);
    check("lat_first_pc", bus.if_pc, RST_PC);
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.if_valid && bus.if_ready) n++;
    end
    check("throughput", n, 16);

    // 2. decoder stall: credit limit stops issue, nothing lost
    @(posedge clk); #1 bus.if_ready = 1'b0;
    f0 = fires;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_req_valid", bus.imem_req_valid, 1'b0);
    check("stall_if_valid", bus.if_valid, 1'b1);
    check("stall_credit", (fires - f0) <= 2, 1'b1);
    @(posedge clk); #1 bus.if_ready = 1'b1;
    repeat (6) @(posedge clk);

    // 3. latency 3 with in-flight requests, then redirect
    @(posedge clk); #1 lat = 3;
    repeat (8) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    check("redir_no_req", bus.imem_req_valid, 1'b0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    next_pop("redir0", pc, ins, flt);
    check("redir_pc0", pc, 8'h40);
    next_pop("redir1", pc, ins, flt);
    check("redir_pc1", pc, 8'h41);

    // 4. halt at pc 7, then redirect 0x10
    @(posedge clk); #1 lat = 1;
    pulse_redirect(8'h00);
    for (int k = 0; k < 40; k++) begin
      next_pop("to7", pc, ins, flt);
      if (pc == 8'h07) break;
    end
    check("saw_pc7", pc, 8'h07);
    pulse_halt();
    @(negedge clk);
    check("halted_set", halted, 1'b1);
    n = 0; p0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.imem_req_valid) n++;
      if (bus.if_valid) p0++;
    end
    check("halt_no_req", n, 0);
    check("halt_no_valid", p0, 0);
    pulse_redirect(8'h10);
    @(negedge clk);
    check("halt_released", halted, 1'b0);
    next_pop("resume", pc, ins, flt);
    check("resume_pc", pc, 8'h10);

    // 5. fault only at pc 5; halt+redirect same cycle
    pulse_redirect(8'h04);
    for (int k = 0; k < 3; k++) begin
      next_pop("fault_seq", pc, ins, flt);
      check("fault_seq_pc", pc, 8'(4 + k));
      check("fault_seq_flag", flt, (k == 1));
    end
    @(posedge clk); #1;
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20;
    @(posedge clk); #1;
    halt = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    check("hr_not_halted", halted, 1'b0);
    next_pop("hr", pc, ins, flt);
    check("hr_pc", pc, 8'h20);

    // Table vectors: encodings at 0x30.. with expected fault flag
    pulse_halt();
    for (int i = 0; i < 6; i++) mem[8'h30 + i] = tbl[i].instr;
    pulse_redirect(8'h30);
    for (int i = 0; i < 6; i++) begin
      next_pop("tbl", pc, ins, flt);
      check("tbl_pc", pc, 8'(8'h30 + i));
      check("tbl_instr", ins, tbl[i].instr);
      check("tbl_fault", flt, tbl[i].fault);
    end

    // 6. async reset mid-stream, refetch from 255 with wrap
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_if_valid", bus.if_valid, 1'b0);
    check("arst_req_valid", bus.imem_req_valid, 1'b0);
    check("arst_req_addr", bus.imem_req_addr, RST_PC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    next_pop("rfetch0", pc, ins, flt);
    check("rfetch_pc0", pc, 8'hFF);
    next_pop("rfetch1", pc, ins, flt);
    check("rfetch_pc1", pc, 8'h00);
    next_pop("rfetch2", pc, ins, flt);
    check("rfetch_pc2", pc, 8'h01);

    // Randomized traffic against the stream scoreboard
    @(posedge clk); #1;
    rand_lat = 1; rand_rdy = 1; rand_ifr = 1;
    p0 = pops;
    for (int c = 0; c < 800; c++) begin
      int r;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      halt           = 1'b0;
      r = $urandom_range(0, 99);
      if (halted_m) begin
        if (r < 15) begin
          redirect_valid = 1'b1;
          redirect_pc    = 8'($urandom_range(0, 255));
        end
      end else if (r < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom_range(0, 255));
      end else if (r < 5) begin
        halt = 1'b1;
      end else if (r < 6) begin
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom_range(0, 255));
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0; halt = 1'b0;
    rand_ifr = 0; rand_rdy = 0; rand_lat = 0;
    bus.if_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("random_progress", (pops - p0) > 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
